// File: rtl/alu_result_fifo.sv
// FIFO for packed ALU results {overflow, zero, carry, data}, with sticky and counted
// overflow status plus a sticky overrun flag for dropped words.
module alu_result_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH+2:0]           in_word,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_overflow,
  output logic                       out_zero,
  output logic                       out_carry,
  output logic [$clog2(DEPTH):0]     level,
  input  logic                       clr_status,
  output logic                       ovf_seen,
  output logic [CNT_W-1:0]           ovf_count,
  output logic                       overrun
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int WW = WIDTH + 3;

  logic [WW-1:0]    mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [WW-1:0]    head_q, head_d;
  logic             ovf_seen_q, ovf_seen_d;
  logic [CNT_W-1:0] ovf_count_q, ovf_count_d;
  logic             overrun_q, overrun_d;

  logic full, empty, push, pop, ovf_event, drop;

  assign full      = (level_q == LW'(DEPTH));
  assign empty     = (level_q == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && !full;
  assign pop       = out_ready && !empty;
  assign ovf_event = push && in_word[WIDTH+2];
  assign drop      = in_valid && full;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    level_d  = level_q;
    if (push && !pop)
      level_d = level_q + LW'(1);
    else if (pop && !push)
      level_d = level_q - LW'(1);
  end

  // Head register tracks mem[rd_ptr]; when the new head is the slot being written
  // this edge it is loaded from in_word, and it holds its value while empty.
  always_comb begin
    head_d = head_q;
    if (level_d != '0) begin
      if (push && (wr_ptr_q == rd_ptr_d))
        head_d = in_word;
      else
        head_d = mem[rd_ptr_d];
    end
  end

  // Set/increment events take priority over clr_status.
  always_comb begin
    ovf_seen_d  = ovf_seen_q;
    ovf_count_d = ovf_count_q;
    overrun_d   = overrun_q;
    if (clr_status) begin
      ovf_seen_d  = 1'b0;
      ovf_count_d = '0;
      overrun_d   = 1'b0;
    end
    if (ovf_event) begin
      ovf_seen_d = 1'b1;
      if (clr_status)
        ovf_count_d = CNT_W'(1);
      else if (ovf_count_q != '1)
        ovf_count_d = ovf_count_q + CNT_W'(1);
    end
    if (drop)
      overrun_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_q] <= in_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      head_q      <= '0;
      ovf_seen_q  <= 1'b0;
      ovf_count_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      head_q      <= head_d;
      ovf_seen_q  <= ovf_seen_d;
      ovf_count_q <= ovf_count_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_data     = head_q[WIDTH-1:0];
  assign out_carry    = head_q[WIDTH];
  assign out_zero     = head_q[WIDTH+1];
  assign out_overflow = head_q[WIDTH+2];
  assign level        = level_q;
  assign ovf_seen     = ovf_seen_q;
  assign ovf_count    = ovf_count_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_alu_result_fifo.sv
// Scoreboard bench for alu_result_fifo: a queue model of the FIFO plus a status model.
module tb_alu_result_fifo;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [WIDTH+2:0]  in_word = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [WIDTH-1:0]  out_data;
  logic              out_overflow, out_zero, out_carry;
  logic [2:0]        level;
  logic              clr_status = 1'b0;
  logic              ovf_seen;
  logic [CNT_W-1:0]  ovf_count;
  logic              overrun;

  alu_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_overflow(out_overflow), .out_zero(out_zero), .out_carry(out_carry),
    .level(level), .clr_status(clr_status),
    .ovf_seen(ovf_seen), .ovf_count(ovf_count), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [WIDTH+2:0] sb_q[$];
  logic             m_seen = 1'b0;
  int               m_cnt  = 0;
  logic             m_ovr  = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_status();
    check("ovf_seen", 64'(ovf_seen), 64'(m_seen));
    check("ovf_count", 64'(ovf_count), 64'(m_cnt));
    check("overrun", 64'(overrun), 64'(m_ovr));
  endtask

  // Called at posedge+1: check current outputs, advance one edge, update the models.
  task automatic cycle();
    bit pu, po, ev;
    check("level", 64'(level), 64'(sb_q.size()));
    check("in_ready", 64'(in_ready), 64'(sb_q.size() < DEPTH));
    check("out_valid", 64'(out_valid), 64'(sb_q.size() != 0));
    if (sb_q.size() != 0)
      check("head", 64'({out_overflow, out_zero, out_carry, out_data}), 64'(sb_q[0]));
    pu = in_valid && (sb_q.size() < DEPTH);
    po = out_ready && (sb_q.size() != 0);
    ev = pu && in_word[WIDTH+2];
    if (clr_status) begin
      m_seen = 1'b0; m_cnt = 0; m_ovr = 1'b0;
    end
    if (ev) begin
      m_seen = 1'b1;
      if (m_cnt < 255) m_cnt++;
    end
    if (in_valid && !(sb_q.size() < DEPTH)) m_ovr = 1'b1;
    @(posedge clk); #1;
    if (po) void'(sb_q.pop_front());
    if (pu) sb_q.push_back(in_word);
    check_status();
    $display("cyc t=%0t push=%0d pop=%0d level=%0d out=%h", $time, pu, po, level, out_data);
  endtask

  task automatic drive(input bit v, input logic [WIDTH+2:0] w, input bit r, input bit c);
    in_valid = v; in_word = w; out_ready = r; clr_status = c;
  endtask

  task automatic drain();
    drive(0, '0, 1, 0);
    for (int i = 0; i < 2 * DEPTH && sb_q.size() != 0; i++) cycle();
    check("drained", 64'(sb_q.size()), 64'(0));
    drive(0, '0, 0, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_level", 64'(level), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out", 64'({out_overflow, out_zero, out_carry, out_data}), 64'(0));
    check_status();
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: single zero-flag word
    drive(1, {1'b0, 1'b1, 1'b0, 32'h0}, 0, 0);
    cycle();
    drive(0, '0, 0, 0);
    check("t1_out_valid", 64'(out_valid), 64'(1));
    check("t1_out_zero", 64'(out_zero), 64'(1));
    check("t1_out_data", 64'(out_data), 64'(0));
    check("t1_level", 64'(level), 64'(1));
    drain();

    // 2: fill, overrun on 5th word, drain in order
    for (int i = 1; i <= 5; i++) begin
      drive(1, {3'b000, 32'(i * 32'h11)}, 0, 0);
      cycle();
    end
    drive(0, '0, 0, 0);
    check("t2_in_ready", 64'(in_ready), 64'(0));
    check("t2_level", 64'(level), 64'(4));
    check("t2_overrun", 64'(overrun), 64'(1));
    drain();

    // 3: steady push+pop at level 2 across pointer wrap
    for (int i = 0; i < 2; i++) begin
      drive(1, {3'b001, 32'(32'h100 + i)}, 0, 0);
      cycle();
    end
    for (int i = 0; i < 10; i++) begin
      drive(1, {3'b010, 32'(32'h200 + i)}, 1, 0);
      cycle();
      check("t3_level", 64'(level), 64'(2));
    end
    drain();

    // 4: saturate overflow counter, then clear
    for (int i = 0; i < 300; i++) begin
      drive(1, {3'b100, 32'(i)}, 1, 0);
      cycle();
    end
    check("t4_ovf_seen", 64'(ovf_seen), 64'(1));
    check("t4_ovf_count", 64'(ovf_count), 64'(255));
    drain();
    drive(0, '0, 0, 1);
    cycle();
    drive(0, '0, 0, 0);
    check("t4_clr_count", 64'(ovf_count), 64'(0));
    check("t4_clr_seen", 64'(ovf_seen), 64'(0));
    check("t4_clr_overrun", 64'(overrun), 64'(0));

    // 5: clear coincident with overflow push
    drive(0, '0, 0, 1);
    cycle();
    drive(1, {3'b100, 32'hABCD}, 0, 1);
    cycle();
    drive(0, '0, 0, 0);
    check("t5_ovf_seen", 64'(ovf_seen), 64'(1));
    check("t5_ovf_count", 64'(ovf_count), 64'(1));
    drain();

    // 6: async reset with level=3, ovf_count=5
    drive(0, '0, 0, 1);
    cycle();
    for (int i = 0; i < 5; i++) begin
      drive(1, {3'b100, 32'(32'h300 + i)}, (i >= 3), 0);
      cycle();
    end
    drive(0, '0, 0, 0);
    check("t6_pre_level", 64'(level), 64'(3));
    check("t6_pre_count", 64'(ovf_count), 64'(5));
    #3 rst_n = 1'b0;
    #1;
    check("t6_level", 64'(level), 64'(0));
    check("t6_out_valid", 64'(out_valid), 64'(0));
    check("t6_in_ready", 64'(in_ready), 64'(1));
    check("t6_ovf_count", 64'(ovf_count), 64'(0));
    sb_q.delete();
    m_seen = 1'b0; m_cnt = 0; m_ovr = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    drive(1, {3'b011, 32'hCAFE_F00D}, 0, 0);
    cycle();
    drive(0, '0, 0, 0);
    check("t6_post_data", 64'(out_data), 64'(32'hCAFE_F00D));
    check("t6_post_flags", 64'({out_overflow, out_zero, out_carry}), 64'(3'b011));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
